// File: rtl/snake_pkg.sv
// Shared types for the snake game controller: FSM states, one-hot move codes
// and the opposite-direction helper.
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_UP    = 4'b0100;
    localparam logic [3:0] DIR_DOWN  = 4'b1000;

    function automatic logic [3:0] opposite(input logic [3:0] dir);
        logic [3:0] opp;
        case (dir)
            DIR_RIGHT: opp = DIR_LEFT;
            DIR_LEFT:  opp = DIR_RIGHT;
            DIR_UP:    opp = DIR_DOWN;
            DIR_DOWN:  opp = DIR_UP;
            default:   opp = DIR_NONE;
        endcase
        return opp;
    endfunction

endpackage

// File: rtl/snake_dir_fifo.sv
// Two-entry queue of pending one-hot direction requests; exposes both the
// head (next to commit) and the tail (most recently accepted).
module snake_dir_fifo (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  logic [3:0] din,
    output logic [3:0] head,
    output logic [3:0] tail,
    output logic       full,
    output logic       empty
);

    logic [3:0] mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    // A full queue can still take a push in the same cycle an entry leaves.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign tail    = mem[~wr_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= 4'b0000;
            mem[1] <= 4'b0000;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/snake_ctrl.sv
// Snake game control FSM: start/pause/over sequencing, button press queueing
// and move pacing. Define SNAKE_SPEEDUP_EN to shorten the move period with score.
module snake_ctrl
    import snake_pkg::*;
#(
    parameter int c_STEP_CYCLES = 25000000,
    parameter int c_MIN_CYCLES  = 2500000,
    parameter int c_SPEED_STEP  = 500000,
    parameter int c_CNT_W       = 25,
    parameter int SCORE_WIDTH   = 14
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_Start,
    input  logic [3:0]             i_Buttons,
    input  logic                   i_Kill,
    input  logic [SCORE_WIDTH-1:0] i_Score,
    output logic [3:0]             o_Direction,
    output logic                   o_GameRst,
    output logic [1:0]             o_State
);

    state_t             state;
    logic [c_CNT_W-1:0] cnt;
    logic [c_CNT_W-1:0] period_q;
    logic [c_CNT_W-1:0] period_calc;
    logic [3:0]         dir_q;
    logic [3:0]         btn_q;
    logic [3:0]         rose;
    logic [3:0]         last_dir;
    logic [3:0]         next_dir;
    logic               press_ok;
    logic               step;
    logic               push;
    logic               pop;
    logic               clear;
    logic [3:0]         fifo_head;
    logic [3:0]         fifo_tail;
    logic               fifo_full;
    logic               fifo_empty;

`ifdef SNAKE_SPEEDUP_EN
    localparam int PW = c_CNT_W + SCORE_WIDTH;
    logic [PW-1:0] reduction;

    // Compare before subtracting so a large score saturates at the floor.
    always_comb begin
        reduction = PW'(i_Score) * PW'(c_SPEED_STEP);
        if (reduction >= PW'(c_STEP_CYCLES - c_MIN_CYCLES)) begin
            period_calc = c_CNT_W'(c_MIN_CYCLES);
        end else begin
            period_calc = c_CNT_W'(PW'(c_STEP_CYCLES) - reduction);
        end
    end
`else
    logic unused_score;
    assign unused_score = ^i_Score;
    assign period_calc  = c_CNT_W'(c_STEP_CYCLES);
`endif

    always_comb begin
        rose     = i_Buttons & ~btn_q;
        press_ok = (rose != 4'b0000) && ((rose & (rose - 4'd1)) == 4'b0000)
                   && (i_Buttons == rose);
        last_dir = fifo_empty ? dir_q : fifo_tail;
        step     = (state == ST_PLAY) && !i_Kill && !i_Start
                   && (cnt == period_q - 1'b1);
        pop      = step && !fifo_empty;
        push     = (state == ST_PLAY) && press_ok && (rose != last_dir)
                   && (rose != opposite(last_dir)) && (!fifo_full || pop);
        clear    = (state == ST_IDLE) && i_Start;
        next_dir = pop ? fifo_head : dir_q;
    end

    snake_dir_fifo u_fifo (
        .clk   (i_Clk),
        .rst   (i_Rst),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (rose),
        .head  (fifo_head),
        .tail  (fifo_tail),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            period_q    <= c_CNT_W'(c_STEP_CYCLES);
            dir_q       <= DIR_RIGHT;
            btn_q       <= 4'b0000;
            o_Direction <= DIR_NONE;
            o_GameRst   <= 1'b0;
        end else begin
            btn_q       <= i_Buttons;
            o_Direction <= DIR_NONE;
            o_GameRst   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_Start) begin
                        state     <= ST_PLAY;
                        o_GameRst <= 1'b1;
                        dir_q     <= DIR_RIGHT;
                        cnt       <= '0;
                        period_q  <= period_calc;
                    end
                end
                ST_PLAY: begin
                    if (i_Kill) begin
                        state <= ST_OVER;
                    end else if (i_Start) begin
                        state <= ST_PAUSE;
                    end else if (step) begin
                        cnt         <= '0;
                        dir_q       <= next_dir;
                        o_Direction <= next_dir;
                        period_q    <= period_calc;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (i_Start) begin
                        state <= ST_PLAY;
                    end
                end
                default: begin
                    if (i_Start) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign o_State = state;

endmodule

// File: tb/tb_snake_ctrl.sv
// Directed bench for snake_ctrl with period 4; expected GameRst/Direction
// pulses are queued with their cycle numbers and matched by a monitor.
module tb_snake_ctrl;

    localparam int G1 = 6;
    localparam int G2 = 28;
    localparam int G3 = 70;
    localparam logic [3:0] K_RST = 4'd1;
    localparam logic [3:0] K_DIR = 4'd2;

    logic        clk;
    logic        i_Rst;
    logic        i_Start;
    logic [3:0]  i_Buttons;
    logic        i_Kill;
    logic [13:0] i_Score;
    logic [3:0]  o_Direction;
    logic        o_GameRst;
    logic [1:0]  o_State;

    int          cyc;
    int          n_checks;
    int          n_fail;
    logic [31:0] exp_q[$];

    snake_ctrl #(
        .c_STEP_CYCLES (4),
        .c_MIN_CYCLES  (2),
        .c_SPEED_STEP  (1),
        .c_CNT_W       (8),
        .SCORE_WIDTH   (14)
    ) dut (
        .i_Clk       (clk),
        .i_Rst       (i_Rst),
        .i_Start     (i_Start),
        .i_Buttons   (i_Buttons),
        .i_Kill      (i_Kill),
        .i_Score     (i_Score),
        .o_Direction (o_Direction),
        .o_GameRst   (o_GameRst),
        .o_State     (o_State)
    );

    // clock / cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic at_cyc(input int n);
        if (cyc > n) begin
            n_checks++;
            n_fail++;
            $display("FAIL schedule: at cycle %0d, required <= %0d", cyc, n);
        end
        while (cyc < n) @(negedge clk);
    endtask

    task automatic expect_ev(input int c, input logic [3:0] kind, input logic [3:0] val);
        logic [31:0] e;
        e = {c[23:0], kind, val};
        exp_q.push_back(e);
    endtask

    task automatic check4(input string name, input logic [3:0] got, input logic [3:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b (cycle %0d)", name, got, req, cyc);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [31:0] got;
        logic [31:0] e;
        if (o_GameRst || o_Direction != 4'b0000) begin
            got = {cyc[23:0], (o_GameRst ? K_RST : K_DIR), (o_GameRst ? 4'b0000 : o_Direction)};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL event: unexpected cyc=%0d kind=%0d val=%b, required none",
                         got[31:8], got[7:4], got[3:0]);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL event: got cyc=%0d kind=%0d val=%b, required cyc=%0d kind=%0d val=%b",
                             got[31:8], got[7:4], got[3:0], e[31:8], e[7:4], e[3:0]);
                end
            end
        end
    end

    // stimulus
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        i_Rst     = 1'b1;
        i_Start   = 1'b0;
        i_Buttons = 4'b0000;
        i_Kill    = 1'b0;
        i_Score   = '0;

        at_cyc(3);
        check4("reset_state", {2'b00, o_State}, 4'b0000);
        check4("reset_dir", o_Direction, 4'b0000);
        check4("reset_gamerst", {3'b000, o_GameRst}, 4'b0000);
        at_cyc(4);
        i_Rst = 1'b0;

        // game 1: pacing, opposite press rejected then UP accepted
        expect_ev(G1, K_RST, 4'b0000);
        expect_ev(G1 + 4, K_DIR, 4'b0001);
        expect_ev(G1 + 8, K_DIR, 4'b0001);
        expect_ev(G1 + 12, K_DIR, 4'b0100);
        expect_ev(G1 + 16, K_DIR, 4'b0100);
        at_cyc(G1 - 1);
        i_Start = 1'b1;
        at_cyc(G1);
        i_Start = 1'b0;
        check4("start_play", {2'b00, o_State}, 4'b0001);
        at_cyc(G1 + 8);
        i_Buttons = 4'b0010;
        at_cyc(G1 + 9);
        i_Buttons = 4'b0000;
        at_cyc(G1 + 10);
        i_Buttons = 4'b0100;
        at_cyc(G1 + 11);
        i_Buttons = 4'b0000;
        at_cyc(G1 + 17);
        i_Start = 1'b1;
        i_Kill  = 1'b1;
        at_cyc(G1 + 18);
        i_Start = 1'b0;
        i_Kill  = 1'b0;
        check4("kill_over_start", {2'b00, o_State}, 4'b0011);
        at_cyc(G1 + 19);
        i_Start = 1'b1;
        at_cyc(G1 + 20);
        i_Start = 1'b0;
        check4("over_to_idle", {2'b00, o_State}, 4'b0000);

        // game 2: queue fill/drop, pause hold, period sampling
        expect_ev(G2, K_RST, 4'b0000);
        expect_ev(G2 + 4, K_DIR, 4'b0001);
        expect_ev(G2 + 8, K_DIR, 4'b0100);
        expect_ev(G2 + 12, K_DIR, 4'b0010);
        expect_ev(G2 + 16, K_DIR, 4'b0010);
        expect_ev(G2 + 25, K_DIR, 4'b0010);
        expect_ev(G2 + 29, K_DIR, 4'b0010);
`ifdef SNAKE_SPEEDUP_EN
        expect_ev(G2 + 32, K_DIR, 4'b0010);
        expect_ev(G2 + 34, K_DIR, 4'b0010);
        expect_ev(G2 + 36, K_DIR, 4'b0010);
`else
        expect_ev(G2 + 33, K_DIR, 4'b0010);
        expect_ev(G2 + 37, K_DIR, 4'b0010);
`endif
        at_cyc(G2 - 1);
        i_Start = 1'b1;
        at_cyc(G2);
        i_Start = 1'b0;
        check4("restart_play", {2'b00, o_State}, 4'b0001);
        at_cyc(G2 + 4);
        i_Buttons = 4'b0100;
        at_cyc(G2 + 5);
        i_Buttons = 4'b0010;
        at_cyc(G2 + 6);
        i_Buttons = 4'b1000;
        at_cyc(G2 + 7);
        i_Buttons = 4'b0000;
        at_cyc(G2 + 18);
        i_Start = 1'b1;
        at_cyc(G2 + 19);
        i_Start = 1'b0;
        check4("pause", {2'b00, o_State}, 4'b0010);
        at_cyc(G2 + 20);
        i_Buttons = 4'b1000;
        at_cyc(G2 + 21);
        i_Buttons = 4'b0000;
        at_cyc(G2 + 22);
        i_Start = 1'b1;
        at_cyc(G2 + 23);
        i_Start = 1'b0;
        check4("resume", {2'b00, o_State}, 4'b0001);
        at_cyc(G2 + 26);
        i_Score = 14'd1;
        at_cyc(G2 + 30);
        i_Score = 14'd5;
        at_cyc(G2 + 37);
        i_Kill = 1'b1;
        at_cyc(G2 + 38);
        i_Kill = 1'b0;
        check4("kill_over", {2'b00, o_State}, 4'b0011);
        at_cyc(G2 + 39);
        i_Start = 1'b1;
        i_Score = '0;
        at_cyc(G2 + 40);
        i_Start = 1'b0;

        // game 3: reset with kill beats the pending step
        expect_ev(G3, K_RST, 4'b0000);
        expect_ev(G3 + 4, K_DIR, 4'b0001);
        at_cyc(G3 - 1);
        i_Start = 1'b1;
        at_cyc(G3);
        i_Start = 1'b0;
        at_cyc(G3 + 6);
        i_Rst  = 1'b1;
        i_Kill = 1'b1;
        at_cyc(G3 + 7);
        check4("midgame_reset_state", {2'b00, o_State}, 4'b0000);
        check4("midgame_reset_dir", o_Direction, 4'b0000);
        at_cyc(G3 + 8);
        i_Rst  = 1'b0;
        i_Kill = 1'b0;
        at_cyc(G3 + 10);
        check4("idle_after_reset", {2'b00, o_State}, 4'b0000);

        at_cyc(G3 + 14);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: got %0d left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_ctrl.md
SNAKE_CTRL -- requirements
Module: snake_ctrl

Interface
REQ-001 SHALL have parameter c_STEP_CYCLES, default 25000000, i_Clk cycles per snake move.
REQ-002 SHALL have parameter c_MIN_CYCLES, default 2500000, floor on move period (speed-up only).
REQ-003 SHALL have parameter c_SPEED_STEP, default 500000, cycles removed from period per score point (speed-up only).
REQ-004 SHALL have parameter c_CNT_W, default 25, step-counter width.
REQ-005 SHALL have parameter SCORE_WIDTH, default 14, score width.
REQ-006 SHALL have port i_Clk  input  1  single system clock; all logic on its rising edge.
REQ-007 SHALL have port i_Rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port i_Start  input  1  single-cycle start/pause/resume pulse.
REQ-009 SHALL have port i_Buttons  input  4  raw direction requests {DOWN,UP,LEFT,RIGHT}.
REQ-010 SHALL have port i_Kill  input  1  out-of-bounds flag from game datapath.
REQ-011 SHALL have port i_Score  input  SCORE_WIDTH  current score from game datapath.
REQ-012 SHALL have port o_Direction  output  4  one-hot move command to datapath; 4'b0000 = no move.
REQ-013 SHALL have port o_GameRst  output  1  single-cycle reset pulse to game datapath.
REQ-014 SHALL have port o_State  output  2  FSM state: IDLE=00, PLAY=01, PAUSE=10, OVER=11.

Function
REQ-015 SHALL implement FSM IDLE->PLAY on i_Start; PLAY->PAUSE on i_Start; PAUSE->PLAY on i_Start; PLAY->OVER on i_Kill; OVER->IDLE on i_Start.
REQ-016 SHALL give i_Kill priority over i_Start in PLAY (same cycle -> OVER).
REQ-017 SHALL, on IDLE->PLAY, assert o_GameRst for exactly one cycle, set committed direction RIGHT, clear queue, clear step counter.
REQ-018 SHALL, in PLAY, increment step counter each cycle; when counter = period-1, step: counter->0, o_Direction = committed direction for exactly that one cycle; o_Direction = 0 in all other cycles/states.
REQ-019 SHALL, at a step, pop queue head (if non-empty) into committed direction before driving o_Direction, so the popped direction is used by that step.
REQ-020 SHALL hold step counter in PAUSE and resume counting from held value on return to PLAY.
REQ-021 SHALL register i_Buttons and detect a press as rising edge of any bit; press valid only if exactly one bit rose and that bit is now the only bit set.
REQ-022 SHALL buffer valid presses in a 2-entry direction FIFO, accepted only in PLAY.
REQ-023 SHALL reject a press equal or opposite to the last-accepted direction (FIFO tail if non-empty, else committed direction).
REQ-024 SHALL drop presses when FIFO full; no overflow state change.
REQ-025 SHALL, on simultaneous push and pop, perform both; occupancy unchanged; reference for REQ-023 is pre-pop tail.
REQ-026 SHALL ignore buttons in IDLE, PAUSE and OVER; FIFO contents retained through PAUSE.
REQ-027 SHALL sample step period at each step (and at game start) so period never changes mid-count.

Reset
REQ-028 SHALL, while i_Rst high at a clock edge, set o_State=IDLE, o_Direction=0, o_GameRst=0, counter=0, FIFO empty, committed=RIGHT, button register=0.
REQ-029 SHALL let reset mid-game override all transitions including i_Kill and pending step.

Configuration
REQ-030 SHALL, with macro SNAKE_SPEEDUP_EN defined, use period = max(c_MIN_CYCLES, c_STEP_CYCLES - i_Score*c_SPEED_STEP), computed without underflow.
REQ-031 SHALL, without SNAKE_SPEEDUP_EN, use fixed period c_STEP_CYCLES and ignore i_Score.

Structure
REQ-032 SHALL place direction codes (RIGHT=0001, LEFT=0010, UP=0100, DOWN=1000), state encodings and an opposite-direction function in shared package snake_pkg.
REQ-033 SHALL implement the direction queue as sub-module snake_dir_fifo (depth 2, 4-bit entries, push/pop/full/empty/tail).

Verification (c_STEP_CYCLES=4, c_MIN_CYCLES=2, c_SPEED_STEP=1)
REQ-034 SHALL cover: reset, i_Start pulse -> o_GameRst high 1 cycle, o_State=01, o_Direction=0001 every 4th cycle only.
REQ-035 SHALL cover: PLAY dir RIGHT, press LEFT then UP -> LEFT rejected, next step o_Direction=0100.
REQ-036 SHALL cover: press UP, LEFT, DOWN within one period -> UP,LEFT queued, DOWN dropped; next two steps 0100 then 0010.
REQ-037 SHALL cover: i_Start and i_Kill same cycle in PLAY -> o_State=11; pause after 2 counts, resume -> step after 2 more cycles.
REQ-038 SHALL cover: with SNAKE_SPEEDUP_EN, i_Score=1 -> period 3; i_Score=5 -> period 2; without macro period stays 4.
